// File: rtl/l1_mem_pkg.sv
// l1_mem_pkg: shared arbiter state encodings, access sizes and grant IDs
// for the L1 miss-path memory arbiter.
package l1_mem_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_I_ADDR  = 3'd1,
        ARB_I_DATA  = 3'd2,
        ARB_D_ADDR  = 3'd3,
        ARB_D_RDATA = 3'd4,
        ARB_D_WRESP = 3'd5
    } arb_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/l1_rr_pick2.sv
// l1_rr_pick2: two-requester round-robin picker; on a tie the requester
// that was not granted last wins.
module l1_rr_pick2
    import l1_mem_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic valid,
    output logic grant
);

    assign valid = req_i | req_d;
    assign grant = (req_i & req_d) ? ~last_grant : (req_d ? GNT_D : GNT_I);

endmodule

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one downstream memory port between the L1 Icache and
// Dcache, holding the grant for a whole transaction and alternating on contention.
module l1_mem_arbiter
    import l1_mem_pkg::*;
#(
    parameter int IBEATS = 4,
    parameter int DBEATS = 4,
    parameter int CNT_W  = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        icache_mem_req,
    input  logic [31:0] icache_mem_addr,
    output logic        mem_icache_addrOK,
    output logic        mem_icache_dataOK,
    output logic [31:0] mem_icache_data,
    input  logic        dcache_mem_req,
    input  logic        dcache_mem_wr,
    input  logic        dcache_mem_uncached,
    input  logic [1:0]  dcache_mem_size,
    input  logic [3:0]  dcache_mem_wstrb,
    input  logic [31:0] dcache_mem_addr,
    input  logic [31:0] dcache_mem_wdata,
    output logic        mem_dcache_addrOK,
    output logic        mem_dcache_dataOK,
    output logic        mem_dcache_bvalid,
    output logic [31:0] mem_dcache_data,
    output logic        arb_mem_req,
    output logic        arb_mem_wr,
    output logic [1:0]  arb_mem_size,
    output logic [3:0]  arb_mem_wstrb,
    output logic [7:0]  arb_mem_len,
    output logic [31:0] arb_mem_addr,
    output logic [31:0] arb_mem_wdata,
    input  logic        mem_arb_addrOK,
    input  logic        mem_arb_dataOK,
    input  logic        mem_arb_bvalid,
    input  logic [31:0] mem_arb_rdata
);

    localparam logic [7:0] ILEN = 8'(IBEATS - 1);
    localparam logic [7:0] DLEN = 8'(DBEATS - 1);

    arb_state_e       state_q, state_d, st;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       len_q, len_d;
    logic             pick_vld, pick_gnt, last_beat;

    l1_rr_pick2 u_pick (
        .req_i      (icache_mem_req),
        .req_d      (dcache_mem_req),
        .last_grant (last_grant_q),
        .valid      (pick_vld),
        .grant      (pick_gnt)
    );

    // Decoding from IDLE while rstn is low drops every handshake in the reset cycle itself.
    assign st        = rstn ? state_q : ARB_IDLE;
    assign last_beat = 8'(cnt_q) == len_q;

    always_comb begin
        state_d           = state_q;
        last_grant_d      = last_grant_q;
        cnt_d             = cnt_q;
        len_d             = len_q;
        arb_mem_req       = 1'b0;
        arb_mem_wr        = 1'b0;
        arb_mem_size      = 2'd0;
        arb_mem_wstrb     = 4'd0;
        arb_mem_len       = 8'd0;
        arb_mem_addr      = 32'd0;
        arb_mem_wdata     = 32'd0;
        mem_icache_addrOK = 1'b0;
        mem_icache_dataOK = 1'b0;
        mem_icache_data   = 32'd0;
        mem_dcache_addrOK = 1'b0;
        mem_dcache_dataOK = 1'b0;
        mem_dcache_bvalid = 1'b0;
        mem_dcache_data   = 32'd0;
        case (st)
            ARB_IDLE: if (pick_vld) state_d = (pick_gnt == GNT_D) ? ARB_D_ADDR : ARB_I_ADDR;
            ARB_I_ADDR: begin
                arb_mem_req       = 1'b1;
                arb_mem_size      = SZ_W;
                arb_mem_len       = ILEN;
                arb_mem_addr      = icache_mem_addr;
                mem_icache_addrOK = mem_arb_addrOK;
                if (mem_arb_addrOK) begin
                    state_d      = ARB_I_DATA;
                    last_grant_d = GNT_I;
                    cnt_d        = '0;
                    len_d        = ILEN;
                end
            end
            ARB_D_ADDR: begin
                arb_mem_req       = 1'b1;
                arb_mem_wr        = dcache_mem_wr;
                arb_mem_size      = dcache_mem_size;
                arb_mem_wstrb     = dcache_mem_wstrb;
                arb_mem_len       = (dcache_mem_wr | dcache_mem_uncached) ? 8'd0 : DLEN;
                arb_mem_addr      = dcache_mem_addr;
                arb_mem_wdata     = dcache_mem_wdata;
                mem_dcache_addrOK = mem_arb_addrOK;
                if (mem_arb_addrOK) begin
                    state_d      = dcache_mem_wr ? ARB_D_WRESP : ARB_D_RDATA;
                    last_grant_d = GNT_D;
                    cnt_d        = '0;
                    len_d        = arb_mem_len;
                end
            end
            ARB_I_DATA: begin
                mem_icache_dataOK = mem_arb_dataOK;
                mem_icache_data   = mem_arb_rdata;
                if (mem_arb_dataOK) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) state_d = ARB_IDLE;
                end
            end
            ARB_D_RDATA: begin
                mem_dcache_dataOK = mem_arb_dataOK;
                mem_dcache_data   = mem_arb_rdata;
                if (mem_arb_dataOK) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) state_d = ARB_IDLE;
                end
            end
            ARB_D_WRESP: begin
                mem_dcache_bvalid = mem_arb_bvalid;
                if (mem_arb_bvalid) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GNT_I;
            cnt_q        <= '0;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter: directed scenarios against a transaction-level model of
// the arbiter, plus hand-computed expectations for each scenario.
module tb_l1_mem_arbiter;
    import l1_mem_pkg::*;

    localparam int IBEATS = 4;
    localparam int DBEATS = 4;

    logic        clk = 0, rstn = 0;
    logic        icache_mem_req = 0;
    logic [31:0] icache_mem_addr = 0;
    logic        mem_icache_addrOK, mem_icache_dataOK;
    logic [31:0] mem_icache_data;
    logic        dcache_mem_req = 0, dcache_mem_wr = 0, dcache_mem_uncached = 0;
    logic [1:0]  dcache_mem_size = 0;
    logic [3:0]  dcache_mem_wstrb = 0;
    logic [31:0] dcache_mem_addr = 0, dcache_mem_wdata = 0;
    logic        mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_bvalid;
    logic [31:0] mem_dcache_data;
    logic        arb_mem_req, arb_mem_wr;
    logic [1:0]  arb_mem_size;
    logic [3:0]  arb_mem_wstrb;
    logic [7:0]  arb_mem_len;
    logic [31:0] arb_mem_addr, arb_mem_wdata;
    logic        mem_arb_addrOK = 0, mem_arb_dataOK = 0, mem_arb_bvalid = 0;
    logic [31:0] mem_arb_rdata = 0;

    always #5 clk = ~clk;

    l1_mem_arbiter #(.IBEATS(IBEATS), .DBEATS(DBEATS), .CNT_W(4)) dut (
        .clk(clk), .rstn(rstn),
        .icache_mem_req(icache_mem_req), .icache_mem_addr(icache_mem_addr),
        .mem_icache_addrOK(mem_icache_addrOK), .mem_icache_dataOK(mem_icache_dataOK),
        .mem_icache_data(mem_icache_data),
        .dcache_mem_req(dcache_mem_req), .dcache_mem_wr(dcache_mem_wr),
        .dcache_mem_uncached(dcache_mem_uncached), .dcache_mem_size(dcache_mem_size),
        .dcache_mem_wstrb(dcache_mem_wstrb), .dcache_mem_addr(dcache_mem_addr),
        .dcache_mem_wdata(dcache_mem_wdata),
        .mem_dcache_addrOK(mem_dcache_addrOK), .mem_dcache_dataOK(mem_dcache_dataOK),
        .mem_dcache_bvalid(mem_dcache_bvalid), .mem_dcache_data(mem_dcache_data),
        .arb_mem_req(arb_mem_req), .arb_mem_wr(arb_mem_wr), .arb_mem_size(arb_mem_size),
        .arb_mem_wstrb(arb_mem_wstrb), .arb_mem_len(arb_mem_len),
        .arb_mem_addr(arb_mem_addr), .arb_mem_wdata(arb_mem_wdata),
        .mem_arb_addrOK(mem_arb_addrOK), .mem_arb_dataOK(mem_arb_dataOK),
        .mem_arb_bvalid(mem_arb_bvalid), .mem_arb_rdata(mem_arb_rdata)
    );

    int n_chk = 0, n_pass = 0, cyc = 0;
    bit chk_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout(input string name);
        n_chk++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Transaction-level model: who owns the port, whether the address was taken, beats left.
    int m_owner = 0, m_left = 0;
    bit m_acc = 0, m_last = 0, m_isw = 0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_owner = 0; m_acc = 0; m_last = 0;
        end else if (m_owner == 0) begin
            if (icache_mem_req || dcache_mem_req) begin
                m_owner = (icache_mem_req && dcache_mem_req) ? (m_last ? 1 : 2) : (dcache_mem_req ? 2 : 1);
                m_acc = 0;
            end
        end else if (!m_acc) begin
            if (mem_arb_addrOK) begin
                m_acc  = 1;
                m_last = (m_owner == 2);
                m_isw  = (m_owner == 2) && dcache_mem_wr;
                m_left = (m_owner == 1) ? IBEATS : (dcache_mem_uncached ? 1 : DBEATS);
            end
        end else if (m_isw) begin
            if (mem_arb_bvalid) m_owner = 0;
        end else if (mem_arb_dataOK) begin
            m_left--;
            if (m_left == 0) m_owner = 0;
        end
    end

    logic e_a, e_d, e_di, e_dd;
    logic e_req, e_wr, e_iaok, e_daok, e_idok, e_ddok, e_bv;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic [7:0]  e_len;
    logic [31:0] e_addr, e_wdata, e_idata, e_ddata;

    always @(negedge clk) if (chk_en) begin
        e_a     = rstn && m_owner != 0 && !m_acc;
        e_d     = m_owner == 2;
        e_di    = rstn && m_owner == 1 && m_acc;
        e_dd    = rstn && m_owner == 2 && m_acc && !m_isw;
        e_req   = e_a;
        e_wr    = e_a && e_d && dcache_mem_wr;
        e_size  = !e_a ? 2'd0 : (e_d ? dcache_mem_size : SZ_W);
        e_wstrb = (e_a && e_d) ? dcache_mem_wstrb : 4'd0;
        e_len   = !e_a ? 8'd0 : !e_d ? 8'(IBEATS - 1) :
                  (dcache_mem_wr || dcache_mem_uncached) ? 8'd0 : 8'(DBEATS - 1);
        e_addr  = !e_a ? 32'd0 : (e_d ? dcache_mem_addr : icache_mem_addr);
        e_wdata = (e_a && e_d) ? dcache_mem_wdata : 32'd0;
        e_iaok  = e_a && !e_d && mem_arb_addrOK;
        e_daok  = e_a && e_d && mem_arb_addrOK;
        e_idok  = e_di && mem_arb_dataOK;
        e_idata = e_di ? mem_arb_rdata : 32'd0;
        e_ddok  = e_dd && mem_arb_dataOK;
        e_ddata = e_dd ? mem_arb_rdata : 32'd0;
        e_bv    = rstn && m_owner == 2 && m_acc && m_isw && mem_arb_bvalid;
        chk("arb_mem_req",       64'(arb_mem_req),       64'(e_req));
        chk("arb_mem_wr",        64'(arb_mem_wr),        64'(e_wr));
        chk("arb_mem_size",      64'(arb_mem_size),      64'(e_size));
        chk("arb_mem_wstrb",     64'(arb_mem_wstrb),     64'(e_wstrb));
        chk("arb_mem_len",       64'(arb_mem_len),       64'(e_len));
        chk("arb_mem_addr",      64'(arb_mem_addr),      64'(e_addr));
        chk("arb_mem_wdata",     64'(arb_mem_wdata),     64'(e_wdata));
        chk("mem_icache_addrOK", 64'(mem_icache_addrOK), 64'(e_iaok));
        chk("mem_dcache_addrOK", 64'(mem_dcache_addrOK), 64'(e_daok));
        chk("mem_icache_dataOK", 64'(mem_icache_dataOK), 64'(e_idok));
        chk("mem_icache_data",   64'(mem_icache_data),   64'(e_idata));
        chk("mem_dcache_dataOK", 64'(mem_dcache_dataOK), 64'(e_ddok));
        chk("mem_dcache_data",   64'(mem_dcache_data),   64'(e_ddata));
        chk("mem_dcache_bvalid", 64'(mem_dcache_bvalid), 64'(e_bv));
    end

    // Observed DUT handshakes, for the scenario-level expectations.
    int ic_beats = 0, dc_beats = 0, dc_bv = 0, dc_aok = 0;
    int iaok_cyc = 0, daok_cyc = 0, bv_cyc = 0;
    bit glog[$];

    always @(negedge clk) begin
        if (mem_icache_dataOK) ic_beats++;
        if (mem_dcache_dataOK) dc_beats++;
        if (mem_dcache_bvalid) begin dc_bv++; bv_cyc = cyc; end
        if (mem_icache_addrOK) begin glog.push_back(1'b0); iaok_cyc = cyc; end
        if (mem_dcache_addrOK) begin glog.push_back(1'b1); dc_aok++; daok_cyc = cyc; end
    end

    // Downstream memory: addrOK one cycle after a request, then len+1 beats or a delayed bvalid.
    int r_ph = 0, r_req = 0, r_left = 0, r_w = 0, bv_dly = 0;
    bit stray_d = 0, stray_b = 0, n_aok, n_dok, n_bv;

    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            r_ph = 0; r_req = 0;
        end else if (arb_mem_req && mem_arb_addrOK) begin
            r_ph = arb_mem_wr ? 3 : 2; r_left = int'(arb_mem_len) + 1; r_w = 0; r_req = 0;
        end else if (r_ph == 2 && mem_arb_dataOK) begin
            r_left--;
            if (r_left == 0) r_ph = 0;
        end else if (r_ph == 3 && mem_arb_bvalid) r_ph = 0;
        if (r_ph == 0 && arb_mem_req) r_req++;
        n_aok = r_ph == 0 && arb_mem_req && r_req > 0;
        n_dok = r_ph == 2 || stray_d;
        n_bv  = stray_b;
        if (r_ph == 3) begin
            r_w++;
            n_bv = n_bv || r_w == bv_dly;
        end
        stray_d = 0; stray_b = 0;
        @(posedge clk); #1;
        mem_arb_addrOK = n_aok;
        mem_arb_dataOK = n_dok;
        mem_arb_bvalid = n_bv;
        mem_arb_rdata  = $urandom;
    end

    logic [7:0]  cap_ilen, cap_len;
    logic [31:0] cap_iaddr, cap_addr, cap_wdata;
    logic        cap_iwr, cap_wr;
    logic [1:0]  cap_size;
    logic [3:0]  cap_wstrb;

    task automatic do_i(input logic [31:0] a);
        icache_mem_req = 1; icache_mem_addr = a;
        for (int k = 0; ; k++) begin
            @(negedge clk);
            if (mem_icache_addrOK) break;
            if (k == 200) begin timeout("icache_addrOK"); break; end
        end
        cap_ilen = arb_mem_len; cap_iaddr = arb_mem_addr; cap_iwr = arb_mem_wr;
        @(posedge clk); #1;
        icache_mem_req = 0;
    endtask

    task automatic do_d(input logic wr, input logic unc, input logic [1:0] sz,
                        input logic [3:0] ws, input logic [31:0] a, input logic [31:0] wd);
        dcache_mem_req = 1; dcache_mem_wr = wr; dcache_mem_uncached = unc;
        dcache_mem_size = sz; dcache_mem_wstrb = ws; dcache_mem_addr = a; dcache_mem_wdata = wd;
        for (int k = 0; ; k++) begin
            @(negedge clk);
            if (mem_dcache_addrOK) break;
            if (k == 200) begin timeout("dcache_addrOK"); break; end
        end
        cap_len = arb_mem_len; cap_addr = arb_mem_addr; cap_wr = arb_mem_wr;
        cap_size = arb_mem_size; cap_wstrb = arb_mem_wstrb; cap_wdata = arb_mem_wdata;
        @(posedge clk); #1;
        dcache_mem_req = 0;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; ; k++) begin
            @(negedge clk);
            if (dut.state_q == ARB_IDLE && r_ph == 0) break;
            if (k == 200) begin timeout(name); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rstn = 0;
        @(posedge clk); #1;
        rstn = 1;
    endtask

    initial begin
        int b_i, b_d, b_bv, nd, alt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 64'(dut.state_q), 64'(ARB_IDLE));
        chk("rst_last_grant", 64'(dut.last_grant_q), 64'(GNT_I));
        chk("rst_req", 64'(arb_mem_req), 64'd0);
        @(posedge clk); #1;
        rstn = 1; chk_en = 1;

        // Icache-only refill
        do_i(32'h1C00_0040);
        chk("i_len", 64'(cap_ilen), 64'd3);
        chk("i_addr", 64'(cap_iaddr), 64'h1C00_0040);
        chk("i_wr", 64'(cap_iwr), 64'd0);
        wait_idle("i_refill_idle");
        chk("i_beats", 64'(ic_beats), 64'd4);
        chk("d_quiet", 64'(dc_beats + dc_bv + dc_aok), 64'd0);

        // Tie right after reset: D first, then I
        pulse_reset();
        glog.delete();
        fork
            do_i(32'h1C00_0080);
            do_d(1'b0, 1'b0, SZ_W, 4'hF, 32'h8000_1000, 32'd0);
        join
        wait_idle("tie_idle");
        chk("tie_n", 64'(glog.size()), 64'd2);
        chk("tie_first_d", 64'(glog[0]), 64'd1);
        chk("tie_second_i", 64'(glog[1]), 64'd0);

        // Dcache halfword write with a late bvalid; Icache held off meanwhile
        bv_dly = 5; b_bv = dc_bv;
        fork
            do_d(1'b1, 1'b0, SZ_H, 4'b0011, 32'h8000_0002, 32'h1234_5678);
            begin repeat (2) @(posedge clk); #1; do_i(32'h1C00_00C0); end
        join
        wait_idle("wr_idle");
        chk("w_wr", 64'(cap_wr), 64'd1);
        chk("w_len", 64'(cap_len), 64'd0);
        chk("w_size", 64'(cap_size), 64'd1);
        chk("w_wstrb", 64'(cap_wstrb), 64'h3);
        chk("w_addr", 64'(cap_addr), 64'h8000_0002);
        chk("w_wdata", 64'(cap_wdata), 64'h1234_5678);
        chk("w_bv_count", 64'(dc_bv - b_bv), 64'd1);
        chk("w_bv_delay", 64'(bv_cyc - daok_cyc), 64'd5);
        chk("w_i_after_bv", 64'(iaok_cyc > bv_cyc), 64'd1);

        // Uncached read, then stray dataOK/bvalid in IDLE
        b_d = dc_beats; b_i = ic_beats; b_bv = dc_bv;
        do_d(1'b0, 1'b1, SZ_W, 4'hF, 32'hBFC0_0010, 32'd0);
        wait_idle("unc_idle");
        chk("u_len", 64'(cap_len), 64'd0);
        chk("u_beats", 64'(dc_beats - b_d), 64'd1);
        stray_d = 1; stray_b = 1;
        repeat (4) @(posedge clk); #1;
        chk("stray_d", 64'(dc_beats - b_d), 64'd1);
        chk("stray_i", 64'(ic_beats - b_i), 64'd0);
        chk("stray_bv", 64'(dc_bv - b_bv), 64'd0);

        // Both held for six transactions: strict alternation
        glog.delete();
        fork
            repeat (3) do_i(32'h1C00_0200);
            repeat (3) do_d(1'b0, 1'b0, SZ_W, 4'hF, 32'h8000_3000, 32'd0);
        join
        wait_idle("rr_idle");
        nd = 0; alt = 0;
        foreach (glog[k]) begin
            if (glog[k]) nd++;
            if (k > 0 && glog[k] != glog[k-1]) alt++;
        end
        chk("rr_n", 64'(glog.size()), 64'd6);
        chk("rr_first_i", 64'(glog[0]), 64'd0);
        chk("rr_d_count", 64'(nd), 64'd3);
        chk("rr_alternations", 64'(alt), 64'd5);

        // Reset after 2 of 4 Icache beats
        b_i = ic_beats;
        do_i(32'h1C00_0100);
        for (int k = 0; ; k++) begin
            @(negedge clk); #1;
            if (ic_beats == b_i + 2) break;
            if (k == 100) begin timeout("i_two_beats"); break; end
        end
        @(posedge clk); #1;
        rstn = 0;
        @(negedge clk);
        chk("mid_rst_req", 64'(arb_mem_req), 64'd0);
        chk("mid_rst_idok", 64'(mem_icache_dataOK), 64'd0);
        chk("mid_rst_idata", 64'(mem_icache_data), 64'd0);
        @(posedge clk); #1;
        rstn = 1;
        @(negedge clk);
        chk("mid_rst_state", 64'(dut.state_q), 64'(ARB_IDLE));
        chk("mid_rst_ibeats", 64'(ic_beats - b_i), 64'd2);
        @(posedge clk); #1;
        b_d = dc_beats;
        do_d(1'b0, 1'b0, SZ_W, 4'hF, 32'h8000_2000, 32'd0);
        wait_idle("post_rst_idle");
        chk("post_rst_len", 64'(cap_len), 64'd3);
        chk("post_rst_beats", 64'(dc_beats - b_d), 64'd4);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Shares one downstream memory port (L2/bus side) between the L1 Icache and the L1 Dcache miss/write paths.
- Uses the existing req/addrOK/dataOK/bvalid handshake on all three sides.
- Holds the grant for the whole transaction: address phase plus all read-data beats, or the write response.
- Arbitrates round-robin between the two caches on contention.

Parameters:
- IBEATS, 4, number of dataOK beats returned for an Icache line refill (power of 2, 1..16).
- DBEATS, 4, number of dataOK beats for a cached Dcache refill; uncached Dcache reads always use 1 beat.
- CNT_W, 4, width of the beat counter (must satisfy 2^CNT_W >= max(IBEATS,DBEATS)).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- icache_mem_req  in  1  Icache read request, held until addrOK.
- icache_mem_addr  in  32  Icache line address.
- mem_icache_addrOK  out  1  Icache address accepted.
- mem_icache_dataOK  out  1  Icache read beat valid.
- mem_icache_data  out  32  Icache read beat.
- dcache_mem_req  in  1  Dcache request, held until addrOK.
- dcache_mem_wr  in  1  1 = write, 0 = read.
- dcache_mem_uncached  in  1  strongly-ordered uncached access; single beat.
- dcache_mem_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes.
- dcache_mem_wstrb  in  4  byte write enables.
- dcache_mem_addr  in  32  Dcache address.
- dcache_mem_wdata  in  32  write data.
- mem_dcache_addrOK  out  1  Dcache address (and write data) accepted.
- mem_dcache_dataOK  out  1  Dcache read beat valid.
- mem_dcache_bvalid  out  1  Dcache write response.
- mem_dcache_data  out  32  Dcache read beat.
- arb_mem_req, arb_mem_wr  out  1  downstream request and direction.
- arb_mem_size  out  2  downstream size.
- arb_mem_wstrb  out  4  downstream byte enables.
- arb_mem_len  out  8  downstream beats-1.
- arb_mem_addr  out  32  downstream address.
- arb_mem_wdata  out  32  downstream write data.
- mem_arb_addrOK, mem_arb_dataOK, mem_arb_bvalid  in  1  downstream handshakes.
- mem_arb_rdata  in  32  downstream read beat.

Behaviour:
- States: IDLE, I_ADDR, I_DATA, D_ADDR, D_RDATA, D_WRESP.
- Registers: 3-bit state, last_grant (0 = I, 1 = D), beat counter, latched len.
- Reset: state = IDLE, last_grant = I (Dcache wins the first tie), counter = 0. All outputs 0 except the address/data buses, which are don't-care but driven 0.
- Reset mid-transaction abandons the transaction, returns to IDLE and drops all handshakes the same cycle.

Grant selection (IDLE):
- If only one req is high, grant it.
- If both are high, grant the one not equal to last_grant.
- Go to I_ADDR or D_ADDR on the next edge; no request is forwarded in the IDLE cycle, so address latency is ≥1 cycle.

ADDR states:
- arb_mem_req = 1; all downstream fields mux combinationally from the granted requester.
- arb_mem_len: IBEATS-1 for Icache; 0 for Dcache writes or uncached reads; DBEATS-1 for Dcache cached reads. arb_mem_wr = 0 for Icache.
- mem_arb_addrOK is routed only to the granted requester's addrOK, same cycle. The non-granted addrOK/dataOK/bvalid stay 0.
- On addrOK: update last_grant, clear the counter, latch len.
  - I goes to I_DATA.
  - D read goes to D_RDATA.
  - D write goes to D_WRESP.
- A requester dropping req before addrOK is a protocol error; the arbiter keeps driving the latched grant.

DATA states:
- mem_arb_dataOK and rdata pass combinationally to the owner. Each beat increments the counter.
- The beat with counter == len returns to IDLE.
- Downstream guarantees the first dataOK is no earlier than the cycle after addrOK. dataOK seen in an ADDR state is ignored.

D_WRESP:
- Wait for mem_arb_bvalid, pass it to mem_dcache_bvalid, then go to IDLE.
- Dcache is allowed to raise a new req during D_WRESP; it is held off until IDLE.

Ordering and fairness:
- Strict one-outstanding: no request is forwarded while a transaction is in flight.
- Back-to-back contention alternates grants, so no requester is starved.
- bvalid or dataOK arriving in IDLE is ignored.

Decomposition:
- Shared package l1_mem_pkg holds:
  - state encodings (ARB_IDLE..ARB_D_WRESP);
  - size constants SZ_B = 0, SZ_H = 1, SZ_W = 2;
  - grant IDs GNT_I = 0, GNT_D = 1.
- One natural sub-module, l1_rr_pick2: two-input round-robin picker, combinational, taking last_grant and returning the winner.

Test Plan:
- Icache-only refill at 0x1C000040, IBEATS = 4 → arb_mem_len = 3; mem_icache_dataOK pulses 4 times; return to IDLE after the 4th beat; Dcache sees no handshakes.
- Icache and Dcache req in the same cycle right after reset → Dcache granted first (last_grant reset = I). Icache granted in the next IDLE, giving the order D, I.
- Dcache write, wstrb = 4'b0011, size = 1, addr 0x8000_0002 → arb_mem_wr = 1, len = 0. mem_dcache_addrOK passes through; the grant is held until bvalid, which is delayed 5 cycles; Icache req during the wait stays unserved until after bvalid.
- Dcache uncached read → len = 0 and a single dataOK; a stray second dataOK in IDLE is not forwarded.
- Both reqs held continuously for 6 transactions → grants strictly alternate, 3 each.
- rstn low during I_DATA after 2 of 4 beats → next cycle state = IDLE and all outputs 0; a new Dcache req is granted normally.
